alarm_sequencer: RTL and testbench

- Downstream consumer of the timekeeping core's alarm-match condition.
- Turns a level "time == alarm time" compare into a timed, beeping buzzer drive.
- Adds snooze, auto-timeout and re-trigger lockout.
- Replaces the bare gating of buzzer_out at the top level; buzzer_out still needs an external buffer and driver.

---
 rtl/classic_clock_pkg.sv | 31 +++
 rtl/alarm_sequencer_tone_gen.sv | 46 ++++
 rtl/alarm_sequencer.sv | 153 +++++++++++++++
 tb/tb_alarm_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/classic_clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | classic_clock_pkg: shared types, defaults and helpers for the clock. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package classic_clock_pkg;

    localparam int CLK_HZ_DEFAULT = 31_500_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RING    = 2'd1,
        SNOOZE  = 2'd2,
        LOCKOUT = 2'd3
    } alarm_state_t;

    // Ceiling log2, floored at 1 so a counter never collapses to zero width.
    function automatic int clog2(input int value);
        int width;
        int pow2;
        width = 0;
        pow2  = 1;
        while (pow2 < value) begin
            pow2  = pow2 * 2;
            width = width + 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_sequencer_tone_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tone_gen: enable-gated square-wave divider with synchronous restart.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tone_gen
    import classic_clock_pkg::*;
#(
    parameter int HALF = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tone
);

    localparam int               CNT_W  = clog2(HALF);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tone;

    // Restart starts a fresh half-period with the output already high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (restart) begin
            r_cnt  <= '0;
            r_tone <= 1'b1;
        end else if (!enable) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (r_cnt == c_last) begin
            r_cnt  <= '0;
            r_tone <= ~r_tone;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign tone = r_tone;

endmodule
`default_nettype wire

// File: rtl/alarm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alarm_sequencer: alarm-match to beeping buzzer with snooze/lockout.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alarm_sequencer
    import classic_clock_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int TONE_HZ     = 1575,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sec_tick,
    input  logic al_on,
    input  logic alarm_match,
    input  logic snooze_pulse,
    output logic buzzer_out,
    output logic ringing,
    output logic snoozing
);

    localparam int HALF    = CLK_HZ / (2 * TONE_HZ);
    localparam int SEC_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int SEC_W   = clog2(SEC_MAX);
    localparam int SNZ_W   = clog2(MAX_SNOOZE + 1);

    localparam logic [SEC_W-1:0] c_ring_last   = SEC_W'(RING_SECS - 1);
    localparam logic [SEC_W-1:0] c_snooze_last = SEC_W'(SNOOZE_SECS - 1);
    localparam logic [SNZ_W-1:0] c_max_snooze  = SNZ_W'(MAX_SNOOZE);

    if (HALF < 1 || RING_SECS < 2 || SNOOZE_SECS < 1 || MAX_SNOOZE < 0) begin : g_param_check
        $error("alarm_sequencer: illegal parameter combination");
    end

    alarm_state_t     r_state;
    alarm_state_t     w_state_nxt;
    logic [SEC_W-1:0] r_sec_cnt;
    logic [SEC_W-1:0] w_sec_nxt;
    logic [SNZ_W-1:0] r_snooze_cnt;
    logic [SNZ_W-1:0] w_snooze_nxt;
    logic             r_beep_phase;
    logic             w_beep_nxt;
    logic             r_match_q;
    logic             w_rise;
    logic             w_tone_restart;
    logic             w_tone_enable;

    assign w_rise = alarm_match & ~r_match_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sec_cnt    <= '0;
            r_snooze_cnt <= '0;
            r_beep_phase <= 1'b0;
            r_match_q    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sec_cnt    <= w_sec_nxt;
            r_snooze_cnt <= w_snooze_nxt;
            r_beep_phase <= w_beep_nxt;
            r_match_q    <= alarm_match;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sec_nxt      = r_sec_cnt;
        w_snooze_nxt   = r_snooze_cnt;
        w_beep_nxt     = r_beep_phase;
        w_tone_restart = 1'b0;

        if (!al_on) begin
            w_state_nxt  = IDLE;
            w_sec_nxt    = '0;
            w_snooze_nxt = '0;
            w_beep_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_state_nxt    = RING;
                        w_sec_nxt      = '0;
                        w_snooze_nxt   = '0;
                        w_beep_nxt     = 1'b1;
                        w_tone_restart = 1'b1;
                    end
                end
                RING: begin
                    // Snooze is checked first so it beats a same-cycle timeout.
                    if (snooze_pulse && (r_snooze_cnt < c_max_snooze)) begin
                        w_state_nxt  = SNOOZE;
                        w_snooze_nxt = r_snooze_cnt + 1'b1;
                        w_sec_nxt    = '0;
                        w_beep_nxt   = 1'b0;
                    end else if (sec_tick) begin
                        if (r_sec_cnt == c_ring_last) begin
                            w_state_nxt = LOCKOUT;
                            w_sec_nxt   = '0;
                            w_beep_nxt  = 1'b0;
                        end else begin
                            w_sec_nxt      = r_sec_cnt + 1'b1;
                            w_beep_nxt     = ~r_beep_phase;
                            w_tone_restart = ~r_beep_phase;
                        end
                    end
                end
                SNOOZE: begin
                    if (sec_tick) begin
                        if (r_sec_cnt == c_snooze_last) begin
                            w_state_nxt    = RING;
                            w_sec_nxt      = '0;
                            w_beep_nxt     = 1'b1;
                            w_tone_restart = 1'b1;
                        end else begin
                            w_sec_nxt = r_sec_cnt + 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (!alarm_match) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // The tone register follows the next state so the buzzer changes on the same edge.
    assign w_tone_enable = (w_state_nxt == RING) && w_beep_nxt;

    tone_gen #(
        .HALF (HALF)
    ) u_tone_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (w_tone_enable),
        .restart (w_tone_restart),
        .tone    (buzzer_out)
    );

    assign ringing  = (r_state == RING);
    assign snoozing = (r_state == SNOOZE);

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alarm_sequencer: scoreboard bench for alarm_sequencer.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alarm_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic sec_tick;
    logic al_on;
    logic alarm_match;
    logic snooze_pulse;
    logic buzzer_out;
    logic ringing;
    logic snoozing;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [2:0] val;
    } exp_t;

    exp_t exp_q[$];

    alarm_sequencer #(
        .CLK_HZ      (1000),
        .TONE_HZ     (100),
        .RING_SECS   (4),
        .SNOOZE_SECS (3),
        .MAX_SNOOZE  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sec_tick     (sec_tick),
        .al_on        (al_on),
        .alarm_match  (alarm_match),
        .snooze_pulse (snooze_pulse),
        .buzzer_out   (buzzer_out),
        .ringing      (ringing),
        .snoozing     (snoozing)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    endtask

    // Expected {ringing, snoozing, buzzer_out} after the edge that brings cyc to c.
    task automatic expect_at(input int c, input string name, input logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.tag = $sformatf("%s@%0d", name, c);
        e.val = v;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check(e.tag, {29'd0, ringing, snoozing, buzzer_out}, {29'd0, e.val});
        end
    end

    // One clock; sec_tick is sampled on every edge that is a multiple of 1000.
    task automatic step();
        @(posedge clk);
        #1;
        sec_tick = (cyc % 1000 == 999);
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic pulse_snooze();
        snooze_pulse = 1'b1;
        step();
        snooze_pulse = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        al_on        = 1'b0;
        alarm_match  = 1'b0;
        snooze_pulse = 1'b0;
        sec_tick     = 1'b0;

        expect_at(2, "reset_idle", 3'b000);
        expect_at(9, "post_reset", 3'b000);
        goto(5);
        reset = 1'b0;
        al_on = 1'b1;

        // Basic ring and beep cadence
        goto(10);
        alarm_match = 1'b1;
        expect_at(11,   "ring_entry",        3'b101);
        expect_at(15,   "tone_high_end",     3'b101);
        expect_at(16,   "tone_toggle_low",   3'b100);
        expect_at(20,   "tone_low_end",      3'b100);
        expect_at(21,   "tone_toggle_high",  3'b101);
        expect_at(1000, "beep_off_start",    3'b100);
        expect_at(1500, "beep_off_mid",      3'b100);
        expect_at(1999, "beep_off_end",      3'b100);
        expect_at(2000, "beep_on_restart",   3'b101);
        expect_at(2004, "beep_on_high",      3'b101);
        expect_at(2005, "beep_on_toggle",    3'b100);

        // Timeout, lockout hold, release and re-ring
        expect_at(3999, "pre_timeout",       3'b100);
        expect_at(4000, "timeout_lockout",   3'b000);
        expect_at(4100, "lockout_hold",      3'b000);
        goto(4100);
        alarm_match = 1'b0;
        goto(4105);
        alarm_match = 1'b1;
        expect_at(4106, "re_ring",           3'b101);

        // Snooze, return to RING without a match
        goto(4200);
        alarm_match = 1'b0;
        expect_at(4201, "snooze_enter",      3'b010);
        expect_at(6999, "snooze_hold",       3'b010);
        expect_at(7000, "snooze_return",     3'b101);
        pulse_snooze();

        // Second snooze accepted, third ignored, then timeout
        goto(7100);
        expect_at(7101,  "snooze2_enter",    3'b010);
        expect_at(9999,  "snooze2_hold",     3'b010);
        expect_at(10000, "snooze2_return",   3'b101);
        pulse_snooze();
        goto(10100);
        expect_at(10101, "snooze3_ignored",  3'b101);
        expect_at(13999, "limit_pre_timeout", 3'b100);
        expect_at(14000, "limit_timeout",    3'b000);
        expect_at(14001, "lockout_release",  3'b000);
        pulse_snooze();

        // Disarm mid-RING
        goto(14010);
        alarm_match = 1'b1;
        expect_at(14011, "disarm_ring",      3'b101);
        expect_at(14101, "disarm_in_ring",   3'b000);
        goto(14100);
        al_on = 1'b0;
        goto(14110);
        al_on = 1'b1;
        expect_at(14150, "rearm_no_rise",    3'b000);
        goto(14150);
        alarm_match = 1'b0;

        // Disarm mid-SNOOZE
        goto(14160);
        alarm_match = 1'b1;
        expect_at(14161, "disarm_ring2",     3'b101);
        expect_at(14201, "disarm_snooze",    3'b010);
        expect_at(14301, "disarm_in_snooze", 3'b000);
        goto(14200);
        pulse_snooze();
        goto(14300);
        al_on       = 1'b0;
        alarm_match = 1'b0;

        // Rise while disarmed, and rise together with al_on falling
        goto(14310);
        alarm_match = 1'b1;
        expect_at(14320, "rise_disarmed",    3'b000);
        goto(14320);
        alarm_match = 1'b0;
        goto(14325);
        al_on = 1'b1;
        goto(14330);
        alarm_match = 1'b1;
        al_on       = 1'b0;
        expect_at(14331, "rise_with_disarm", 3'b000);
        expect_at(14339, "rise_with_disarm2", 3'b000);
        goto(14340);
        al_on       = 1'b1;
        alarm_match = 1'b0;

        // Reset mid-ring
        goto(14350);
        alarm_match = 1'b1;
        expect_at(14351, "pre_reset_ring",   3'b101);
        expect_at(14361, "reset_mid_ring",   3'b000);
        expect_at(14365, "after_reset",      3'b000);
        goto(14360);
        reset       = 1'b1;
        alarm_match = 1'b0;
        step();
        reset = 1'b0;

        // Snooze collides with the timeout tick
        goto(14370);
        alarm_match = 1'b1;
        expect_at(14371, "collide_ring",     3'b101);
        expect_at(17999, "collide_pre",      3'b100);
        expect_at(18000, "collide_snooze",   3'b010);
        expect_at(20999, "collide_hold",     3'b010);
        expect_at(21000, "collide_return",   3'b101);
        goto(17999);
        pulse_snooze();

        goto(21010);
        al_on = 1'b0;
        step();
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
